// File: rtl/fetch_realigner.sv
// rtl/fetch_realigner.sv - halfword fetch buffer presenting one aligned 16/32-bit instruction per cycle
module fetch_realigner #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [31:0]                        in_rdata_i,
  input  logic                               flush_i,
  input  logic [31:0]                        flush_addr_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [31:0]                        out_instr_o,
  output logic                               out_is_compressed_o,
  output logic [31:0]                        out_addr_o,
  output logic [$clog2(2*DEPTH):0]           count_o
);

  localparam int unsigned SLOTS = 2 * DEPTH;
  localparam int unsigned AW    = $clog2(SLOTS);
  localparam int unsigned CW    = AW + 1;

  logic [15:0]   slots [SLOTS];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc;
  logic          drop_lo;

  logic [15:0]   hw0;
  logic [15:0]   hw1;
  logic          compressed;
  logic          push;
  logic          pop;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  assign hw0        = slots[rd_ptr];
  assign hw1        = slots[rd_ptr + AW'(1)];
  assign compressed = (hw0[1:0] != 2'b11);

  // Readiness is judged on the pre-pop count so a full buffer never over-fills.
  assign in_ready_o  = (count <= CW'(SLOTS - 2));
  assign out_valid_o = ((count != '0) && compressed) || (count >= CW'(2));

  assign push   = in_valid_i & in_ready_o & ~flush_i;
  assign pop    = out_valid_o & out_ready_i & ~flush_i;
  assign push_n = push ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n  = pop ? (compressed ? 2'd1 : 2'd2) : 2'd0;

  always_comb begin
    out_instr_o         = '0;
    out_is_compressed_o = 1'b0;
    if (out_valid_o) begin
      out_instr_o         = compressed ? {16'h0000, hw0} : {hw1, hw0};
      out_is_compressed_o = compressed;
    end
  end

  assign out_addr_o = pc;
  assign count_o    = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc      <= BOOT_ADDR;
      drop_lo <= BOOT_ADDR[1];
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc      <= flush_addr_i & ~32'h1;
      drop_lo <= flush_addr_i[1];
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
      if (pop) begin
        pc <= pc + (compressed ? 32'd2 : 32'd4);
      end
      if (push) begin
        drop_lo <= 1'b0;
      end
    end
  end

  // A redirect into the upper halfword keeps only bits [31:16] of the first word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        slots[i] <= '0;
      end
    end else if (push) begin
      if (drop_lo) begin
        slots[wr_ptr] <= in_rdata_i[31:16];
      end else begin
        slots[wr_ptr]          <= in_rdata_i[15:0];
        slots[wr_ptr + AW'(1)] <= in_rdata_i[31:16];
      end
    end
  end

endmodule

// File: tb/tb_fetch_realigner.sv
// tb/tb_fetch_realigner.sv - randomized and directed check of fetch_realigner against a halfword-queue model
module tb_fetch_realigner;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned SLOTS     = 2 * DEPTH;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;

  logic        clk;
  logic        rst_ni;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic        flush;
  logic [31:0] flush_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_is_compressed;
  logic [31:0] out_addr;
  logic [$clog2(2*DEPTH):0] count;

  int n_checks;
  int n_fail;

  // Model state: the buffered halfwords in program order, the PC of the head and the drop flag.
  logic [15:0] mq[$];
  logic [31:0] mpc;
  logic        mdrop;

  fetch_realigner #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT_ADDR)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_rdata_i          (in_rdata),
    .flush_i             (flush),
    .flush_addr_i        (flush_addr),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_instr_o         (out_instr),
    .out_is_compressed_o (out_is_compressed),
    .out_addr_o          (out_addr),
    .count_o             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cmp();
    return (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic logic m_valid();
    return m_cmp() || (mq.size() >= 2);
  endfunction

  function automatic logic [31:0] m_instr();
    if (!m_valid()) return 32'h0;
    return m_cmp() ? {16'h0000, mq[0]} : {mq[1], mq[0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc   = BOOT_ADDR;
    mdrop = BOOT_ADDR[1];
  endtask

  task automatic check_model();
    check_val("out_valid", out_valid, m_valid());
    check_val("in_ready", in_ready, mq.size() <= SLOTS - 2);
    check_val("count", count, mq.size());
    check_val("out_instr", out_instr, m_instr());
    check_val("out_is_compressed", out_is_compressed, m_valid() && m_cmp());
    check_val("out_addr", out_addr, mpc);
  endtask

  // Called at a falling edge: checks outputs, drives one cycle of inputs, advances the model.
  task automatic step(input logic v, input logic [31:0] w, input logic rdy,
                      input logic fl, input logic [31:0] fa);
    logic mv, mc, mr;
    check_model();
    in_valid   = v;
    in_rdata   = w;
    out_ready  = rdy;
    flush      = fl;
    flush_addr = fa;
    mv = m_valid();
    mc = m_cmp();
    mr = (mq.size() <= SLOTS - 2);
    if (fl) begin
      mq.delete();
      mpc   = fa & ~32'h1;
      mdrop = fa[1];
    end else begin
      if (mv && rdy) begin
        void'(mq.pop_front());
        if (!mc) void'(mq.pop_front());
        mpc += mc ? 32'd2 : 32'd4;
      end
      if (v && mr) begin
        if (mdrop) begin
          mq.push_back(w[31:16]);
          mdrop = 1'b0;
        end else begin
          mq.push_back(w[15:0]);
          mq.push_back(w[31:16]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid   = 1'b0;
    in_rdata   = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    flush_addr = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] held;
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    // Two compressed instructions followed by an aligned 32-bit one.
    step(1'b1, 32'h0001_4501, 1'b1, 1'b0, '0);
    check_val("tp1_instr0", out_instr, 32'h0000_4501);
    check_val("tp1_addr0", out_addr, 32'h80);
    step(1'b1, 32'h00A0_0593, 1'b1, 1'b0, '0);
    check_val("tp1_instr1", out_instr, 32'h0000_0001);
    check_val("tp1_addr1", out_addr, 32'h82);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    check_val("tp1_instr2", out_instr, 32'h00A0_0593);
    check_val("tp1_addr2", out_addr, 32'h84);
    check_val("tp1_cmp2", out_is_compressed, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0);

    // 32-bit instruction straddling two fetch words.
    do_reset();
    step(1'b1, 32'h0593_4501, 1'b1, 1'b0, '0);
    check_val("str_instr0", out_instr, 32'h0000_4501);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      check_val("str_wait_valid", out_valid, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    step(1'b1, 32'h4505_00A0, 1'b1, 1'b0, '0);
    check_val("str_instr1", out_instr, 32'h00A0_0593);
    check_val("str_addr1", out_addr, 32'h82);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    check_val("str_instr2", out_instr, 32'h0000_4505);
    check_val("str_addr2", out_addr, 32'h86);
    step(1'b0, '0, 1'b0, 1'b0, '0);

    // Flush to an upper-halfword target discards the flush-cycle word and the lower half of the next.
    do_reset();
    step(1'b1, 32'h0001_4501, 1'b0, 1'b0, '0);
    step(1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_0102);
    check_val("fl_count", count, 0);
    step(1'b1, 32'h4501_ABCD, 1'b1, 1'b0, '0);
    check_val("fl_instr", out_instr, 32'h0000_4501);
    check_val("fl_addr", out_addr, 32'h102);
    step(1'b0, '0, 1'b0, 1'b0, '0);

    // Fill to capacity under backpressure, then drain while still pushing.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check_val("full_ready", in_ready, 1'b0);
    check_val("full_count", count, SLOTS);
    held = out_instr;
    step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check_val("full_hold", out_instr, held);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0, '0);

    // Flush, pop and push in the same cycle.
    step(1'b1, $urandom, 1'b1, 1'b1, 32'h0000_0200);
    check_val("fpp_count", count, 0);
    check_val("fpp_addr", out_addr, 32'h200);

    // Asynchronous reset between clock edges with five halfwords buffered.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0082);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check_val("ar_count_before", count, 5);
    #2 rst_ni = 1'b0;
    #1;
    check_val("ar_count", count, 0);
    check_val("ar_valid", out_valid, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    step(1'b1, 32'h0000_4501, 1'b1, 1'b0, '0);
    check_val("ar_instr", out_instr, 32'h0000_4501);
    check_val("ar_addr", out_addr, 32'h80);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom);
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
